// File: rtl/rf_pkg.sv
// Shared types and helpers for the multiport register file.
// The RF_BYPASS_EN macro (see rf_multiport) selects write-first reads.
package rf_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } rf_state_t;

  localparam int RF_MAX_RD = 4;

  // Low bit of element idx in a flattened bus of w-bit elements.
  function automatic int slice_lo(input int idx, input int w);
    return idx * w;
  endfunction

endpackage

// File: rtl/rf_clear_seq.sv
// Clear sequencer: sweeps zeros through the array after reset or clr_req,
// holding init_busy until the last entry has been written.
module rf_clear_seq
  import rf_pkg::*;
#(
  parameter  int DEPTH = 32,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_req,
  output logic          clr_we,
  output logic [AW-1:0] clr_addr,
  output logic          init_busy
);

  rf_state_t     state;
  rf_state_t     state_nx;
  logic [AW-1:0] ptr;
  logic [AW-1:0] ptr_nx;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR;
      ptr   <= '0;
    end else begin
      state <= state_nx;
      ptr   <= ptr_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    ptr_nx    = ptr;
    clr_we    = 1'b0;
    init_busy = 1'b0;
    unique case (state)
      CLEAR: begin
        clr_we    = 1'b1;
        init_busy = 1'b1;
        ptr_nx    = ptr + AW'(1);
        if (ptr == AW'(DEPTH - 1)) begin
          state_nx = RUN;
        end
      end
      RUN: begin
        if (clr_req) begin
          state_nx = CLEAR;
          ptr_nx   = '0;
        end
      end
      default: begin
        state_nx = CLEAR;
        ptr_nx   = '0;
      end
    endcase
  end

  assign clr_addr = ptr;

endmodule

// File: rtl/rf_multiport.sv
// Parametrised multi-read-port register file with clear sweep and
// registered reads. Define RF_BYPASS_EN for write-first same-cycle reads.
module rf_multiport
  import rf_pkg::*;
#(
  parameter  int DW       = 32,
  parameter  int DEPTH    = 32,
  parameter  int NUM_RD   = 2,
  parameter  int ZERO_REG = 1,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we,
  input  logic [AW-1:0]        waddr,
  input  logic [DW-1:0]        wdata,
  input  logic [NUM_RD*AW-1:0] raddr,
  output logic [NUM_RD*DW-1:0] rdata,
  input  logic                 clr_req,
  output logic                 init_busy
);

  logic [DW-1:0] mem [DEPTH];
  logic          clr_we;
  logic [AW-1:0] clr_addr;
  logic          wz;
  logic          wr_ok;

  rf_clear_seq #(
    .DEPTH(DEPTH)
  ) u_seq (
    .clk      (clk),
    .rst      (rst),
    .clr_req  (clr_req),
    .clr_we   (clr_we),
    .clr_addr (clr_addr),
    .init_busy(init_busy)
  );

  assign wz    = (ZERO_REG != 0) && (waddr == '0);
  assign wr_ok = !init_busy && we && !wz;

  // Sweep owns the array while busy; user writes only land in RUN.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_addr] <= '0;
    end else if (wr_ok) begin
      mem[waddr] <= wdata;
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [AW-1:0] ra;
    logic [DW-1:0] rq;
    logic          rz;

    assign ra = raddr[slice_lo(i, AW) +: AW];
    assign rz = (ZERO_REG != 0) && (ra == '0);

    always_ff @(posedge clk) begin
      if (rst) begin
        rq <= '0;
      end else if (init_busy || rz) begin
        rq <= '0;
`ifdef RF_BYPASS_EN
      end else if (wr_ok && (waddr == ra)) begin
        rq <= wdata;
`endif
      end else begin
        rq <= mem[ra];
      end
    end

    assign rdata[slice_lo(i, DW) +: DW] = rq;
  end

endmodule

// File: tb/tb_rf_multiport.sv
// Directed bench for rf_multiport: vector table plus clear/reset sequences.
module tb_rf_multiport;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          we;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;
  logic [2*AW-1:0] raddr;
  logic [2*DW-1:0] rdata;
  logic          clr_req;
  logic          init_busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rf_multiport dut (
    .clk      (clk),
    .rst      (rst),
    .we       (we),
    .waddr    (waddr),
    .wdata    (wdata),
    .raddr    (raddr),
    .rdata    (rdata),
    .clr_req  (clr_req),
    .init_busy(init_busy)
  );

  typedef struct {
    logic          we;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic [AW-1:0] ra0;
    logic [AW-1:0] ra1;
    logic [DW-1:0] e0;
    logic [DW-1:0] e1;
  } vec_t;

  vec_t vecs [8];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] rd0();
    return rdata[DW-1:0];
  endfunction

  function automatic logic [DW-1:0] rd1();
    return rdata[2*DW-1:DW];
  endfunction

  initial begin
    int n;
    int zbad;
    logic [DW-1:0] exp_byp;

    vecs[0] = '{1'b1, 5'd7,  32'h0000_00B7, 5'd0,  5'd0, 32'h0,         32'h0};
    vecs[1] = '{1'b0, 5'd0,  32'h0,         5'd5,  5'd7, 32'h0,         32'h0000_00B7};
    vecs[2] = '{1'b1, 5'd9,  32'h0000_0055, 5'd7,  5'd7, 32'h0000_00B7, 32'h0000_00B7};
    vecs[3] = '{1'b1, 5'd0,  32'hFFFF_FFFF, 5'd9,  5'd9, 32'h0000_0055, 32'h0000_0055};
    vecs[4] = '{1'b1, 5'd31, 32'hDEAD_BEEF, 5'd0,  5'd0, 32'h0,         32'h0};
    vecs[5] = '{1'b0, 5'd0,  32'h0,         5'd31, 5'd0, 32'hDEAD_BEEF, 32'h0};
    vecs[6] = '{1'b1, 5'd7,  32'h1234_5678, 5'd31, 5'd1, 32'hDEAD_BEEF, 32'h0};
    vecs[7] = '{1'b0, 5'd0,  32'h0,         5'd7,  5'd9, 32'h1234_5678, 32'h0000_0055};

    rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0;
    raddr = {5'd31, 5'd5}; clr_req = 1'b0;

    // Reset and initial sweep
    tick;
    chk("rst_busy", 32'(init_busy), 32'd1);
    chk("rst_rd0", rd0(), 32'h0);
    chk("rst_rd1", rd1(), 32'h0);
    rst = 1'b0;
    n = 0;
    while (init_busy && n < 100) begin
      tick;
      n++;
    end
    chk("init_sweep_len", 32'(n), 32'd32);
    tick;
    chk("init_rd5", rd0(), 32'h0);
    chk("init_rd31", rd1(), 32'h0);

    // Table-driven RUN vectors
    for (int i = 0; i < 8; i++) begin
      we = vecs[i].we; waddr = vecs[i].wa; wdata = vecs[i].wd;
      raddr = {vecs[i].ra1, vecs[i].ra0};
      tick;
      chk($sformatf("vec%0d_p0", i), rd0(), vecs[i].e0);
      chk($sformatf("vec%0d_p1", i), rd1(), vecs[i].e1);
    end

    // Same-cycle write/read of addr 9 (old value 0x55)
`ifdef RF_BYPASS_EN
    exp_byp = 32'h0000_1234;
`else
    exp_byp = 32'h0000_0055;
`endif
    we = 1'b1; waddr = 5'd9; wdata = 32'h0000_1234; raddr = {5'd9, 5'd9};
    tick;
    chk("same_cyc_p0", rd0(), exp_byp);
    chk("same_cyc_p1", rd1(), exp_byp);
    we = 1'b0;
    tick;
    chk("after_wr_p0", rd0(), 32'h0000_1234);

    // Zero register ignores writes, even same-cycle
    we = 1'b1; waddr = 5'd0; wdata = 32'hFFFF_FFFF; raddr = {5'd0, 5'd0};
    tick;
    chk("zero_same_p0", rd0(), 32'h0);
    chk("zero_same_p1", rd1(), 32'h0);
    we = 1'b0;
    tick;
    chk("zero_next_p0", rd0(), 32'h0);
    chk("zero_next_p1", rd1(), 32'h0);

    // Clear with second clr_req and a write on the last sweep cycle
    we = 1'b1; waddr = 5'd3; wdata = 32'h0000_00AA; raddr = {5'd3, 5'd3};
    tick;
    we = 1'b0;
    tick;
    chk("fill3", rd0(), 32'h0000_00AA);
    clr_req = 1'b1; raddr = {5'd7, 5'd7};
    tick;
    clr_req = 1'b0;
    chk("clr_busy_rise", 32'(init_busy), 32'd1);
    n = 0; zbad = 0;
    while (init_busy && n < 100) begin
      clr_req = (n == 5);
      we      = (n == 31);
      waddr   = 5'd3;
      wdata   = 32'h0000_BEEF;
      tick;
      if (rd0() !== '0 || rd1() !== '0) zbad++;
      n++;
    end
    clr_req = 1'b0; we = 1'b0;
    chk("clr_sweep_len", 32'(n), 32'd32);
    chk("clr_rd_zero", 32'(zbad), 32'd0);
    raddr = {5'd3, 5'd3};
    tick;
    chk("clr_addr3_p0", rd0(), 32'h0);
    chk("clr_addr3_p1", rd1(), 32'h0);
    raddr = {5'd9, 5'd7};
    tick;
    chk("clr_addr7", rd0(), 32'h0);
    chk("clr_addr9", rd1(), 32'h0);

    // Reset mid-sweep restarts the sweep
    we = 1'b1; waddr = 5'd4; wdata = 32'h0000_0044; raddr = {5'd4, 5'd4};
    tick;
    we = 1'b0; clr_req = 1'b1;
    tick;
    clr_req = 1'b0;
    for (int k = 0; k < 10; k++) tick;
    rst = 1'b1; clr_req = 1'b1;
    tick;
    rst = 1'b0; clr_req = 1'b0;
    chk("rst_mid_busy", 32'(init_busy), 32'd1);
    chk("rst_mid_rd", rd0(), 32'h0);
    n = 0;
    while (init_busy && n < 100) begin
      tick;
      n++;
    end
    chk("rst_mid_len", 32'(n), 32'd32);
    tick;
    chk("rst_mid_addr4", rd0(), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
